// File: rtl/unimem11.sv
// ---------------------------------------------------------------------------
// unimem11 - Unibus slave memory bank backed by block RAM.
//
// Answers DATI/DATIP (read), DATO (word write) and DATOB (byte write) bus
// cycles for addresses inside a 2^(AWIDTH+1)-byte window at a programmable
// base. The ARM side can enable the bank, move it, and load or inspect the
// contents through a small register file with an auto-incrementing pointer.
//
// Ports
//   CLOCK, RESET        system clock, synchronous active-high reset
//   armwrite            ARM register write strobe (one cycle)
//   armraddr/armwaddr   ARM register read/write index
//   armwdata            ARM write data
//   armrdata            ARM read data (combinational)
//   a_in_h/c_in_h/d_in_h  Unibus address, control, data
//   init_in_h           Unibus INIT
//   del_msyn_in_h       deskewed MSYN
//   d_out_h, ssyn_out_h read data and slave sync driven to the bus
//
// ARM registers
//   0  ID 32'h554D300D
//   1  {enable, 13'b0, base[17:0]}  (low AWIDTH+1 base bits read as 0)
//   2  {cycles[15:0], zeros, ptr}    (write sets ptr, clears cycles)
//   3  {16'b0, mem[ptr]}             (read/write post-increment ptr)
//   4-7 32'hDEADBEEF
// ---------------------------------------------------------------------------
module unimem11 #(
  parameter int AWIDTH = 12
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armwrite,
  input  logic [2:0]  armraddr,
  input  logic [2:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic [17:0] a_in_h,
  input  logic [1:0]  c_in_h,
  input  logic [15:0] d_in_h,
  input  logic        init_in_h,
  input  logic        del_msyn_in_h,
  output logic [15:0] d_out_h,
  output logic        ssyn_out_h
);

  localparam int          DEPTH   = 1 << AWIDTH;
  localparam logic [31:0] ID_WORD = 32'h554D300D;
  localparam logic [31:0] FILLER  = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_RESPOND,
    S_HOLD
  } state_t;

  // Storage and state
  logic [15:0]         mem [DEPTH];
  state_t              state_q, state_d;
  logic                en_q;
  logic [17:AWIDTH+1]  base_q;
  logic [AWIDTH-1:0]   ptr_q, ptr_d;
  logic [15:0]         cycles_q, cycles_d;

  // Bus cycle latches
  logic [AWIDTH-1:0]   idx_q;
  logic [1:0]          ctl_q;
  logic [15:0]         dat_q;
  logic                bsel_q;
  logic                ssyn_q, ssyn_d;
  logic [15:0]         dout_q, dout_d;
  logic [15:0]         bus_rdata_q;
  logic [15:0]         prefetch_q;

  // ARM write deferral and read-increment tracking
  logic                pend_q, pend_d;
  logic [AWIDTH-1:0]   pend_addr_q, pend_addr_d;
  logic [15:0]         pend_data_q, pend_data_d;
  logic                rd3_q;
  logic                rdinc_done_q;

  // RAM write port
  logic                mem_we;
  logic [AWIDTH-1:0]   mem_waddr;
  logic [15:0]         mem_wdata;
  logic                bus_we;
  logic [15:0]         bus_wdata;

  logic                hit, start, arm_blocked;
  logic                arm_wr1, arm_wr2, arm_wr3, rd_inc;
  logic                unused_wdata;

  assign unused_wdata = &{1'b0, armwdata[30:18]};

  assign hit     = en_q && (a_in_h[17:AWIDTH+1] == base_q);
  assign start   = (state_q == S_IDLE) && del_msyn_in_h && hit && !ssyn_q && !init_in_h;
  assign arm_wr1 = armwrite && (armwaddr == 3'd1);
  assign arm_wr2 = armwrite && (armwaddr == 3'd2);
  assign arm_wr3 = armwrite && (armwaddr == 3'd3);

  // One pointer bump per contiguous stretch of armraddr == 3 lasting two cycles.
  assign rd_inc  = (armraddr == 3'd3) && rd3_q && !rdinc_done_q;

  // The RAM port is busy with the bus read (LOOKUP) and the bus write
  // (RESPOND); INIT abandons the bus cycle and frees the port at once.
  assign arm_blocked = ((state_q == S_LOOKUP) || (state_q == S_RESPOND)) && !init_in_h;

  assign d_out_h    = dout_q;
  assign ssyn_out_h = ssyn_q;

  // ---------------------------------------------------------------------------
  // Bus FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge CLOCK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Bus FSM: next state
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    state_d = state_q;
    if (init_in_h) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (start) state_d = S_LOOKUP;
        S_LOOKUP:  state_d = S_RESPOND;
        S_RESPOND: state_d = S_HOLD;
        S_HOLD:    if (!del_msyn_in_h) state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Bus FSM: outputs (next values of SSYN / read data, and the bus write)
  always_comb begin
    ssyn_d    = ssyn_q;
    dout_d    = dout_q;
    bus_we    = 1'b0;
    bus_wdata = dat_q;
    if (ctl_q[0]) begin
      // DATOB: a_in_h[0] picks the byte lane, the other byte is preserved.
      bus_wdata = bsel_q ? {dat_q[15:8], bus_rdata_q[7:0]}
                         : {bus_rdata_q[15:8], dat_q[7:0]};
    end
    if (init_in_h) begin
      ssyn_d = 1'b0;
      dout_d = '0;
    end else begin
      case (state_q)
        S_RESPOND: begin
          ssyn_d = 1'b1;
          if (!ctl_q[1]) dout_d = bus_rdata_q;   // DATI and DATIP
          else           bus_we = 1'b1;          // DATO and DATOB
        end
        S_HOLD: begin
          if (!del_msyn_in_h) begin
            ssyn_d = 1'b0;
            dout_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RAM write arbitration. The bus owns the port in RESPOND; an ARM write
  // arriving while the port is busy waits in a one-entry slot and drains on
  // the first free cycle, so a same-word ARM write lands after the bus write.
  // The slot holds one write: the ARM must not issue two register-3 writes
  // within a single LOOKUP/RESPOND window.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_we      = 1'b0;
    mem_waddr   = idx_q;
    mem_wdata   = bus_wdata;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;

    if (bus_we) begin
      mem_we = 1'b1;
    end else if (!arm_blocked) begin
      if (pend_q) begin
        mem_we    = 1'b1;
        mem_waddr = pend_addr_q;
        mem_wdata = pend_data_q;
        pend_d    = 1'b0;
      end else if (arm_wr3) begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = armwdata[15:0];
      end
    end

    if (arm_wr3 && (arm_blocked || pend_q)) begin
      pend_d      = 1'b1;
      pend_addr_d = ptr_q;
      pend_data_d = armwdata[15:0];
    end
  end

  always_comb begin
    ptr_d = ptr_q + AWIDTH'(arm_wr3) + AWIDTH'(rd_inc);
    if (arm_wr2) ptr_d = armwdata[AWIDTH-1:0];

    cycles_d = cycles_q;
    if (arm_wr2)                                       cycles_d = '0;
    else if ((state_q == S_RESPOND) && !init_in_h)     cycles_d = cycles_q + 16'd1;
  end

  // ---------------------------------------------------------------------------
  // Block RAM: port A is the shared read/write port (bus read when idle of
  // writes), port B continuously refreshes the ARM prefetch word at ptr.
  // ---------------------------------------------------------------------------
  // NOTE: the memory array has no reset; block RAM cannot be cleared in one
  // cycle and its power-up contents are undefined by design.
  always_ff @(posedge CLOCK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    else        bus_rdata_q    <= mem[idx_q];
    prefetch_q <= mem[ptr_q];
  end

  // Bus cycle latches and outputs
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      ssyn_q <= 1'b0;
      dout_q <= '0;
      idx_q  <= '0;
      ctl_q  <= '0;
      dat_q  <= '0;
      bsel_q <= 1'b0;
    end else begin
      ssyn_q <= ssyn_d;
      dout_q <= dout_d;
      if (start) begin
        idx_q  <= a_in_h[AWIDTH:1];
        ctl_q  <= c_in_h;
        dat_q  <= d_in_h;
        bsel_q <= a_in_h[0];
      end
    end
  end

  // ARM-side registers
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      en_q         <= 1'b0;
      base_q       <= '0;
      ptr_q        <= '0;
      cycles_q     <= '0;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      rd3_q        <= 1'b0;
      rdinc_done_q <= 1'b0;
    end else begin
      if (arm_wr1) begin
        en_q   <= armwdata[31];
        base_q <= armwdata[17:AWIDTH+1];
      end
      ptr_q        <= ptr_d;
      cycles_q     <= cycles_d;
      pend_q       <= pend_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      rd3_q        <= (armraddr == 3'd3);
      rdinc_done_q <= (armraddr == 3'd3) && (rdinc_done_q || rd_inc);
    end
  end

  // ARM read mux
  always_comb begin
    armrdata = FILLER;
    case (armraddr)
      3'd0: armrdata = ID_WORD;
      3'd1: armrdata = {en_q, 13'b0, base_q, {(AWIDTH+1){1'b0}}};
      3'd2: armrdata = {cycles_q, {(16-AWIDTH){1'b0}}, ptr_q};
      3'd3: armrdata = {16'b0, prefetch_q};
      default: armrdata = FILLER;
    endcase
  end

endmodule

// File: tb/tb_unimem11.sv
// ---------------------------------------------------------------------------
// tb_unimem11 - directed self-checking bench for unimem11 (AWIDTH = 12).
// Expected read data is queued when a read cycle is launched and compared
// when SSYN returns the data.
// ---------------------------------------------------------------------------
module tb_unimem11;

  localparam int AW = 12;
  localparam logic [1:0] C_DATI  = 2'b00;
  localparam logic [1:0] C_DATIP = 2'b01;
  localparam logic [1:0] C_DATO  = 2'b10;
  localparam logic [1:0] C_DATOB = 2'b11;

  logic        CLOCK;
  logic        RESET;
  logic        armwrite;
  logic [2:0]  armraddr, armwaddr;
  logic [31:0] armwdata, armrdata;
  logic [17:0] a_in_h;
  logic [1:0]  c_in_h;
  logic [15:0] d_in_h;
  logic        init_in_h;
  logic        del_msyn_in_h;
  logic [15:0] d_out_h;
  logic        ssyn_out_h;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] sb_q[$];

  unimem11 #(.AWIDTH(AW)) dut (
    .CLOCK         (CLOCK),
    .RESET         (RESET),
    .armwrite      (armwrite),
    .armraddr      (armraddr),
    .armwaddr      (armwaddr),
    .armwdata      (armwdata),
    .armrdata      (armrdata),
    .a_in_h        (a_in_h),
    .c_in_h        (c_in_h),
    .d_in_h        (d_in_h),
    .init_in_h     (init_in_h),
    .del_msyn_in_h (del_msyn_in_h),
    .d_out_h       (d_out_h),
    .ssyn_out_h    (ssyn_out_h)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic arm_wr(input logic [2:0] idx, input logic [31:0] data);
    armwaddr = idx;
    armwdata = data;
    armwrite = 1'b1;
    tick();
    armwrite = 1'b0;
  endtask

  task automatic arm_rd(input logic [2:0] idx, output logic [31:0] v);
    armraddr = idx;
    #1;
    v = armrdata;
    armraddr = 3'd0;
  endtask

  // Full handshake: checks SSYN latency (3) and release latency (1).
  task automatic bus_cycle(input logic [17:0] addr, input logic [1:0] ctl,
                           input logic [15:0] data, input string tag,
                           output logic [15:0] rd);
    int lat;
    int rel;
    a_in_h = addr;
    c_in_h = ctl;
    d_in_h = data;
    del_msyn_in_h = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (ssyn_out_h) begin
        lat = k;
        break;
      end
    end
    rd = d_out_h;
    check({tag, " ssyn latency"}, lat, 3);
    del_msyn_in_h = 1'b0;
    rel = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (!ssyn_out_h && d_out_h == 16'h0) begin
        rel = k;
        break;
      end
    end
    check({tag, " release latency"}, rel, 1);
    tick();
  endtask

  task automatic do_write(input logic [17:0] addr, input logic [1:0] ctl,
                          input logic [15:0] data, input string tag);
    logic [15:0] rd;
    bus_cycle(addr, ctl, data, tag, rd);
  endtask

  task automatic do_read(input logic [17:0] addr, input logic [1:0] ctl,
                         input logic [15:0] exp, input string tag);
    logic [15:0] rd;
    logic [15:0] e;
    sb_q.push_back(exp);
    bus_cycle(addr, ctl, 16'h0, tag, rd);
    e = sb_q.pop_front();
    check({tag, " data"}, {16'h0, rd}, {16'h0, e});
  endtask

  task automatic expect_miss(input logic [17:0] addr, input string tag);
    int cnt;
    a_in_h = addr;
    c_in_h = C_DATI;
    del_msyn_in_h = 1'b1;
    cnt = 0;
    repeat (2000) begin
      tick();
      if (ssyn_out_h) cnt++;
    end
    del_msyn_in_h = 1'b0;
    tick();
    check(tag, cnt, 0);
  endtask

  // DATO with an ARM register-3 write placed in LOOKUP (1) or RESPOND (2).
  task automatic dato_with_arm(input logic [17:0] addr, input logic [15:0] bus_data,
                               input logic [15:0] arm_data, input int arm_cycle,
                               input string tag);
    a_in_h = addr;
    c_in_h = C_DATO;
    d_in_h = bus_data;
    del_msyn_in_h = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == arm_cycle) begin
        armwaddr = 3'd3;
        armwdata = {16'h0, arm_data};
        armwrite = 1'b1;
      end else begin
        armwrite = 1'b0;
      end
    end
    check({tag, " ssyn"}, {31'h0, ssyn_out_h}, 1);
    del_msyn_in_h = 1'b0;
    tick();
    check({tag, " release"}, {31'h0, ssyn_out_h}, 0);
    tick();
  endtask

  initial begin
    logic [31:0] v;
    int cnt;
    int lat;

    RESET = 1'b1; init_in_h = 1'b1;
    armwrite = 1'b0; armraddr = 3'd0; armwaddr = 3'd0; armwdata = '0;
    a_in_h = '0; c_in_h = '0; d_in_h = '0; del_msyn_in_h = 1'b0;
    repeat (3) @(posedge CLOCK);
    #1;
    RESET = 1'b0; init_in_h = 1'b0;
    tick();

    // Reset state
    check("reset ssyn", {31'h0, ssyn_out_h}, 0);
    check("reset dout", {16'h0, d_out_h}, 0);
    arm_rd(3'd0, v); check("reg0 id", v, 32'h554D300D);
    arm_rd(3'd1, v); check("reg1 reset", v, 32'h0);
    arm_rd(3'd2, v); check("reg2 reset", v, 32'h0);
    arm_rd(3'd5, v); check("reg5 filler", v, 32'hDEADBEEF);
    arm_rd(3'd7, v); check("reg7 filler", v, 32'hDEADBEEF);

    // Enable at 060000; low base bits and unused bits are dropped
    arm_wr(3'd1, 32'hC000_6ABC);
    arm_rd(3'd1, v); check("reg1 base", v, 32'h8000_6000);

    // Word write then read back, cycle counter
    do_write(18'o060010, C_DATO, 16'o123456, "dato 060010");
    do_read (18'o060010, C_DATI, 16'o123456, "dati 060010");
    arm_rd(3'd2, v); check("cycles after 2", {16'h0, v[31:16]}, 2);
    do_read (18'o060010, C_DATIP, 16'o123456, "datip 060010");

    // Byte writes
    do_write(18'o060010, C_DATO,  16'o000377, "dato 377");
    do_write(18'o060011, C_DATOB, 16'o177400, "datob high");
    do_read (18'o060010, C_DATI,  16'o177777, "after datob high");
    do_write(18'o060010, C_DATOB, 16'o000000, "datob low");
    do_read (18'o060010, C_DATI,  16'o177400, "after datob low");

    // Top word of the bank; next address and below-base miss
    do_write(18'o077776, C_DATO, 16'o052525, "dato top");
    do_read (18'o077776, C_DATI, 16'o052525, "dati top");
    expect_miss(18'o057776, "miss below base");
    expect_miss(18'o100000, "miss past top");
    arm_wr(3'd1, 32'h0000_6000);
    expect_miss(18'o060010, "miss disabled");
    arm_wr(3'd1, 32'h8000_6000);

    // ARM loads through ptr, bus reads them back
    arm_wr(3'd2, 32'd5);
    arm_wr(3'd3, 32'd1);
    arm_wr(3'd3, 32'd2);
    arm_wr(3'd3, 32'd3);
    arm_rd(3'd2, v); check("ptr after 3 writes", v, 32'd8);
    do_read(18'o060012, C_DATI, 16'd1, "dati 060012");
    do_read(18'o060014, C_DATI, 16'd2, "dati 060014");
    do_read(18'o060016, C_DATI, 16'd3, "dati 060016");
    arm_rd(3'd2, v); check("reg2 cycles+ptr", v, {16'd3, 16'd8});

    // ARM prefetch read and read post-increment
    arm_wr(3'd2, 32'd5);
    tick(); tick();
    armraddr = 3'd3;
    #1;
    check("reg3 prefetch", armrdata, 32'd1);
    @(posedge CLOCK);
    @(posedge CLOCK);
    #1;
    armraddr = 3'd0;
    arm_rd(3'd2, v); check("ptr after read", v, 32'd6);
    tick(); tick();
    arm_rd(3'd3, v); check("reg3 refreshed", v, 32'd2);

    // Pointer wrap at the last word
    arm_wr(3'd2, 32'd4095);
    arm_wr(3'd3, 32'h0000_BEEF);
    arm_rd(3'd2, v); check("ptr wrap", v, 32'd0);
    do_read(18'o077776, C_DATI, 16'hBEEF, "dati last via arm");

    // MSYN dropped during LOOKUP: one-cycle SSYN, write still lands
    a_in_h = 18'o060030; c_in_h = C_DATO; d_in_h = 16'o065432;
    del_msyn_in_h = 1'b1;
    tick();
    del_msyn_in_h = 1'b0;
    cnt = 0;
    repeat (6) begin
      tick();
      if (ssyn_out_h) cnt++;
    end
    check("early msyn drop pulse", cnt, 1);
    do_read(18'o060030, C_DATI, 16'o065432, "early drop committed");

    // INIT during HOLD
    a_in_h = 18'o060010; c_in_h = C_DATI; del_msyn_in_h = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (ssyn_out_h) begin
        lat = k;
        break;
      end
    end
    check("init pre ssyn latency", lat, 3);
    check("init pre dout", {16'h0, d_out_h}, {16'h0, 16'o177400});
    init_in_h = 1'b1;
    tick();
    check("init ssyn", {31'h0, ssyn_out_h}, 0);
    check("init dout", {16'h0, d_out_h}, 0);
    init_in_h = 1'b0;
    del_msyn_in_h = 1'b0;
    tick();
    do_read(18'o060010, C_DATI, 16'o177400, "after init");

    // ARM write racing a bus DATO
    arm_wr(3'd2, 32'd8);
    dato_with_arm(18'o060020, 16'h1111, 16'h2222, 2, "race respond");
    dato_with_arm(18'o060024, 16'h3333, 16'h4444, 1, "race lookup");
    arm_rd(3'd2, v); check("ptr after races", {16'h0, v[15:0]}, 32'd10);
    do_read(18'o060020, C_DATI, 16'h2222, "arm wins same word");
    do_read(18'o060022, C_DATI, 16'h4444, "arm write in lookup");
    do_read(18'o060024, C_DATI, 16'h3333, "bus write beside arm");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
